// File: rtl/icache_refill_pkg.sv
// Shared CPU package for the instruction-cache refill engine: FSM encoding and AXI burst constants.
package icache_refill_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_REFRESH,
        ST_HOLD
    } refill_state_e;

    localparam int         WORD_W       = 32;
    localparam logic [7:0] ARLEN_LINE   = 8'd15;
    localparam logic [2:0] ARSIZE_WORD  = 3'b010;
    localparam logic [1:0] ARBURST_INCR = 2'b01;

endpackage

// File: rtl/icache_refill.sv
// Instruction-cache line refill over a 16-beat AXI INCR read burst.
// Optional completed-refill counter enabled by ICACHE_REFILL_PERF_CNT_EN.
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int CACHELINE_WD = 512
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    icache_miss,
    input  logic [31:0]             icache_raddr,
    output logic                    icache_refresh,
    output logic [CACHELINE_WD-1:0] icache_cacheline_new,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [31:0]             rdata,
    input  logic                    rlast,
    output logic [31:0]             refill_cnt
);

    refill_state_e state;
    logic [3:0]    beat_cnt;
    logic          unused_raddr_lsb;

    assign arlen            = ARLEN_LINE;
    assign arsize           = ARSIZE_WORD;
    assign arburst          = ARBURST_INCR;
    assign unused_raddr_lsb = ^icache_raddr[5:0];

    // arvalid/rready/icache_refresh are registered alongside the state they belong to
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= ST_IDLE;
            araddr               <= '0;
            beat_cnt             <= '0;
            icache_cacheline_new <= '0;
            arvalid              <= 1'b0;
            rready               <= 1'b0;
            icache_refresh       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (icache_miss) begin
                        state    <= ST_AR;
                        araddr   <= {icache_raddr[31:6], 6'b0};
                        beat_cnt <= '0;
                        arvalid  <= 1'b1;
                    end
                end
                ST_AR: begin
                    if (arvalid && arready) begin
                        state   <= ST_R;
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                    end
                end
                ST_R: begin
                    if (rvalid && rready) begin
                        icache_cacheline_new[WORD_W*beat_cnt +: WORD_W] <= rdata;
                        beat_cnt <= beat_cnt + 4'd1;
                        if (rlast) begin
                            state          <= ST_REFRESH;
                            rready         <= 1'b0;
                            icache_refresh <= 1'b1;
                        end
                    end
                end
                ST_REFRESH: begin
                    state          <= ST_HOLD;
                    icache_refresh <= 1'b0;
                end
                // One dead cycle so a miss level still high from this refill is not re-taken.
                ST_HOLD: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state          <= ST_IDLE;
                    arvalid        <= 1'b0;
                    rready         <= 1'b0;
                    icache_refresh <= 1'b0;
                end
            endcase
        end
    end

`ifdef ICACHE_REFILL_PERF_CNT_EN
    logic [31:0] refill_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refill_cnt_q <= '0;
        end else if (state == ST_REFRESH) begin
            refill_cnt_q <= refill_cnt_q + 32'd1;
        end
    end

    assign refill_cnt = refill_cnt_q;
`else
    assign refill_cnt = 32'd0;
`endif

endmodule

// File: doc/icache_refill.md
ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 SHALL have parameter CACHELINE_WD, default 512, instruction cache line width in bits (16 words of 32 bits).
REQ-002 SHALL have ports, one per line (name  direction  width  meaning):
  clk  input  1  single clock, all state on rising edge
  reset  input  1  asynchronous, active-high reset
  icache_miss  input  1  instruction cache reports a miss
  icache_raddr  input  32  miss address from the instruction cache
  icache_refresh  output  1  one-cycle pulse: refill line valid, cache writes it
  icache_cacheline_new  output  CACHELINE_WD  refilled line
  arvalid  output  1  AXI read address valid
  arready  input  1  AXI read address ready
  araddr  output  32  line-aligned burst address
  arlen  output  8  burst length minus one
  arsize  output  3  beat size
  arburst  output  2  burst type
  rvalid  input  1  AXI read data valid
  rready  output  1  AXI read data ready
  rdata  input  32  read beat data
  rlast  input  1  last beat of burst
  refill_cnt  output  32  completed-refill counter (see Configuration)

Function
REQ-003 SHALL implement FSM states IDLE, AR, R, REFRESH, HOLD.
REQ-004 SHALL move IDLE->AR on a clock edge where icache_miss=1, latching {icache_raddr[31:6],6'b0} into araddr.
REQ-005 SHALL assert arvalid only in AR, hold araddr stable there, and move AR->R on the edge where arvalid&&arready.
REQ-006 SHALL drive constant arlen=8'd15, arsize=3'b010, arburst=2'b01 (INCR).
REQ-007 SHALL assert rready only in R; each rvalid&&rready beat writes rdata to word slot given by a 4-bit beat counter, beat 0 to bits [31:0], beat 15 to bits [511:480].
REQ-008 SHALL clear the beat counter on IDLE->AR and increment it per accepted beat, wrapping 15->0.
REQ-009 SHALL move R->REFRESH on the accepted beat with rlast=1, regardless of beat count; rvalid without rready is ignored.
REQ-010 SHALL assert icache_refresh=1 for exactly the one cycle spent in REFRESH, then move to HOLD.
REQ-011 SHALL spend exactly one cycle in HOLD, ignoring icache_miss, then return to IDLE, so a stale miss level cannot restart a refill.
REQ-012 SHALL hold icache_cacheline_new stable from REFRESH until beats of the next refill overwrite it.
REQ-013 Latency: arvalid first high one cycle after the miss edge; icache_refresh high one cycle after the rlast beat.
REQ-014 SHALL keep icache_miss changes during AR/R/REFRESH/HOLD from affecting araddr or state.

Reset
REQ-015 SHALL, on reset=1 at any time including mid-burst, asynchronously return to IDLE and clear araddr, beat counter, icache_cacheline_new, refill_cnt, arvalid, rready, icache_refresh to 0.
REQ-016 SHALL leave an interrupted AXI burst to be reset by the system interconnect, not drained.

Configuration
REQ-017 SHALL, with ICACHE_REFILL_PERF_CNT_EN defined, increment refill_cnt by 1 on each REFRESH cycle, wrapping 32'hFFFF_FFFF->0.
REQ-018 SHALL, without ICACHE_REFILL_PERF_CNT_EN, tie refill_cnt to 32'd0 and instantiate no counter register.

Structure
REQ-019 SHALL place FSM state encodings and AXI constants (ARLEN_LINE, ARSIZE_WORD, ARBURST_INCR) in the shared cpu package.
REQ-020 SHALL be a single module with no sub-module; FSM and datapath inline.

Verification
REQ-021 Miss at 0x1C00_0044, arready=1 immediately, 16 beats rdata=beat index, rlast on beat 15 -> araddr=0x1C00_0040, line word k=k, one refresh pulse one cycle after beat 15.
REQ-022 arready held low 5 cycles -> arvalid and araddr=0x1C00_0040 stable all 5 cycles; no rready before handshake.
REQ-023 rvalid gaps between beats (rvalid=0 on alternate cycles) -> line identical to gapless case; refresh timing relative to rlast unchanged.
REQ-024 icache_miss kept high through HOLD -> only one refill, one refresh pulse; new miss two cycles after refresh starts second refill.
REQ-025 reset pulsed at beat 7 -> next cycle state IDLE, all outputs 0; subsequent miss at 0x0000_1000 completes normally.
REQ-026 Three refills with ICACHE_REFILL_PERF_CNT_EN defined -> refill_cnt=3; without macro -> refill_cnt=0 throughout.
